// File: rtl/coherence_bus_ctrl_if.sv
// Bundle of per-core I/D cache, coherence and RAM signals around the coherence bus controller.
// The master modport is the controller's view; slave is the view of the cores and the RAM.
interface coherence_bus_ctrl_if #(
   parameter int CPUS   = 4,
   parameter int WORD_W = 32
);
   logic [CPUS-1:0]        iREN;
   logic [CPUS*WORD_W-1:0] iaddr;
   logic [CPUS-1:0]        iwait;
   logic [CPUS*WORD_W-1:0] iload;

   logic [CPUS-1:0]        dREN;
   logic [CPUS-1:0]        dWEN;
   logic [CPUS*WORD_W-1:0] daddr;
   logic [CPUS*WORD_W-1:0] dstore;
   logic [CPUS-1:0]        dwait;
   logic [CPUS*WORD_W-1:0] dload;

   logic [CPUS-1:0]        ccwrite;
   logic [CPUS-1:0]        cctrans;
   logic [CPUS-1:0]        ccwait;
   logic [CPUS-1:0]        ccinv;
   logic [CPUS*WORD_W-1:0] ccsnoopaddr;

   logic                   ramREN;
   logic                   ramWEN;
   logic [WORD_W-1:0]      ramaddr;
   logic [WORD_W-1:0]      ramstore;
   logic [WORD_W-1:0]      ramload;
   logic [1:0]             ramstate;

   modport master (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );

   modport slave (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
      input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr,
             ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// N-core coherence bus controller: round-robin data arbitration, snoop broadcast,
// cache-to-cache forwarding and a single-port RAM shared with instruction fetches.
module coherence_bus_ctrl #(
   parameter int CPUS   = 4,
   parameter int WORD_W = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   coherence_bus_ctrl_if.master bus
);
   localparam int         IDW        = (CPUS > 1) ? $clog2(CPUS) : 1;
   localparam logic [1:0] RAM_ACCESS = 2'd2;

   typedef enum logic [2:0] {IDLE, ARB, SNOOP, C2C, MEM} state_t;

   state_t          state_q, state_d;
   logic [IDW-1:0]  dptr_q, dptr_d;
   logic [IDW-1:0]  iptr_q, iptr_d;
   logic [IDW-1:0]  req_q, req_d;
   logic [IDW-1:0]  resp_q, resp_d;

   logic [IDW:0]    iSel, dSel;
   logic [IDW-1:0]  iWin, dWin;
   logic [CPUS-1:0] dAny, reqMask, othersTrans, othersWrite;
   logic            ramReady;

   // Result MSB flags a hit; lower bits are the first candidate at or after ptr.
   function automatic logic [IDW:0] rrSearch(input logic [CPUS-1:0] cand,
                                            input logic [IDW-1:0]  ptr);
      logic [IDW:0] res;
      int           pos;
      res = '0;
      for (int i = CPUS - 1; i >= 0; i--) begin
         pos = (int'(ptr) + i) % CPUS;
         if (cand[pos[IDW-1:0]]) res = {1'b1, pos[IDW-1:0]};
      end
      return res;
   endfunction

   function automatic logic [IDW-1:0] nextId(input logic [IDW-1:0] id);
      return (int'(id) == CPUS - 1) ? '0 : id + 1'b1;
   endfunction

   assign dAny        = bus.dREN | bus.dWEN;
   assign iSel        = rrSearch(bus.iREN, iptr_q);
   assign dSel        = rrSearch(dAny, dptr_q);
   assign iWin        = iSel[IDW-1:0];
   assign dWin        = dSel[IDW-1:0];
   assign reqMask     = {{(CPUS-1){1'b0}}, 1'b1} << req_q;
   assign othersTrans = bus.cctrans & ~reqMask;
   assign othersWrite = bus.ccwrite & ~reqMask;
   assign ramReady    = (bus.ramstate == RAM_ACCESS);

   // Outputs depend on the live RAM status, so they are decoded from state each cycle;
   // reset forces every output back to its idle value without waiting for a clock.
   always_comb begin
      state_d         = state_q;
      dptr_d          = dptr_q;
      iptr_d          = iptr_q;
      req_d           = req_q;
      resp_d          = resp_q;
      bus.iwait       = '1;
      bus.dwait       = '1;
      bus.ccwait      = '0;
      bus.ccinv       = '0;
      bus.ramREN      = 1'b0;
      bus.ramWEN      = 1'b0;
      bus.ramaddr     = '0;
      bus.ramstore    = '0;
      bus.iload       = '0;
      bus.dload       = '0;
      bus.ccsnoopaddr = '0;

      if (!rst_i) begin
         case (state_q)
            IDLE: begin
               if (iSel[IDW]) begin
                  bus.ramREN                             = 1'b1;
                  bus.ramaddr                            = bus.iaddr[int'(iWin)*WORD_W +: WORD_W];
                  bus.iload[int'(iWin)*WORD_W +: WORD_W] = bus.ramload;
                  bus.iwait[iWin]                        = !ramReady;
                  if (ramReady) iptr_d = nextId(iWin);
               end
               if (|dAny) state_d = ARB;
            end

            ARB: begin
               bus.ccwait = '1;
               if (dSel[IDW]) begin
                  req_d   = dWin;
                  dptr_d  = nextId(dWin);
                  state_d = SNOOP;
               end else begin
                  state_d = IDLE;
               end
            end

            SNOOP: begin
               for (int k = 0; k < CPUS; k++) begin
                  if (k != int'(req_q)) begin
                     bus.ccwait[k]                     = 1'b1;
                     bus.ccinv[k]                      = bus.ccwrite[req_q];
                     bus.ccsnoopaddr[k*WORD_W +: WORD_W] = bus.daddr[int'(req_q)*WORD_W +: WORD_W];
                  end
               end
               if (|othersTrans) begin
                  state_d = SNOOP;
               end else if (|othersWrite) begin
                  for (int k = CPUS - 1; k >= 0; k--) begin
                     if (othersWrite[k]) resp_d = k[IDW-1:0];
                  end
                  state_d = C2C;
               end else begin
                  state_d = MEM;
               end
            end

            // The dirty copy goes to the requester and to RAM together, one word per ACCESS.
            C2C: begin
               bus.ccwait        = ~reqMask;
               bus.dload[int'(req_q)*WORD_W +: WORD_W] = bus.dstore[int'(resp_q)*WORD_W +: WORD_W];
               bus.ramWEN        = bus.dWEN[resp_q];
               bus.ramaddr       = bus.daddr[int'(resp_q)*WORD_W +: WORD_W];
               bus.ramstore      = bus.dstore[int'(resp_q)*WORD_W +: WORD_W];
               bus.dwait[resp_q] = !ramReady;
               bus.dwait[req_q]  = !ramReady;
               if (!bus.dWEN[resp_q]) state_d = IDLE;
            end

            MEM: begin
               bus.ccwait       = ~reqMask;
               bus.ramREN       = bus.dREN[req_q];
               bus.ramWEN       = bus.dWEN[req_q];
               bus.ramaddr      = bus.daddr[int'(req_q)*WORD_W +: WORD_W];
               bus.ramstore     = bus.dstore[int'(req_q)*WORD_W +: WORD_W];
               bus.dload[int'(req_q)*WORD_W +: WORD_W] = bus.ramload;
               bus.dwait[req_q] = !ramReady;
               if (!dAny[req_q]) state_d = IDLE;
            end

            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         dptr_q  <= '0;
         iptr_q  <= '0;
         req_q   <= '0;
         resp_q  <= '0;
      end else begin
         state_q <= state_d;
         dptr_q  <= dptr_d;
         iptr_q  <= iptr_d;
         req_q   <= req_d;
         resp_q  <= resp_d;
      end
   end
endmodule
